// File: rtl/reg_file_mp_pkg.sv
// rtl/reg_file_mp_pkg.sv - shared parameters, read-source enum and bypass switch (RF_COMMIT_BYPASS_EN)
package reg_file_mp_pkg;

    localparam int XLEN_DEF         = 32;
    localparam int REG_NUM_DEF      = 32;
    localparam int REG_W_DEF        = 5;
    localparam int ROB_W_DEF        = 4;
    localparam int ISSUE_PORTS_DEF  = 2;
    localparam int COMMIT_PORTS_DEF = 2;

`ifdef RF_COMMIT_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        SRC_ZERO   = 2'd0,
        SRC_FWD    = 2'd1,
        SRC_BYPASS = 2'd2,
        SRC_STORED = 2'd3
    } rd_src_e;

endpackage

// File: rtl/reg_file_mp_read_port.sv
// rtl/reg_file_mp_read_port.sv - one operand read port: x0, older-slot rename, commit bypass, stored entry
module rf_read_port
    import reg_file_mp_pkg::*;
#(
    parameter int XLEN         = XLEN_DEF,
    parameter int REG_W        = REG_W_DEF,
    parameter int ROB_W        = ROB_W_DEF,
    parameter int ISSUE_PORTS  = ISSUE_PORTS_DEF,
    parameter int COMMIT_PORTS = COMMIT_PORTS_DEF
) (
    input  logic [REG_W-1:0]              rs_idx,
    input  logic [XLEN-1:0]               st_val,
    input  logic                          st_busy,
    input  logic [ROB_W-1:0]              st_tag,
    input  logic [ISSUE_PORTS-1:0]        issue_valid,
    input  logic [ISSUE_PORTS*REG_W-1:0]  issue_rd,
    input  logic [ISSUE_PORTS*ROB_W-1:0]  issue_rob_index,
    input  logic [COMMIT_PORTS-1:0]       commit_valid,
    input  logic [COMMIT_PORTS*ROB_W-1:0] commit_rob_index,
    input  logic [COMMIT_PORTS*XLEN-1:0]  commit_val,
    output logic [XLEN-1:0]               rd_val,
    output logic                          rd_busy,
    output logic [ROB_W-1:0]              rd_tag
);

    rd_src_e          src;
    logic [ROB_W-1:0] fwd_tag;
    logic [XLEN-1:0]  byp_val;
    logic             hit_fwd;
    logic             hit_byp;

    // issue_valid arrives pre-masked to older slots; ascending scans let the youngest match win
    always_comb begin
        hit_fwd = 1'b0;
        fwd_tag = '0;
        hit_byp = 1'b0;
        byp_val = '0;
        for (int j = 0; j < ISSUE_PORTS; j++) begin
            if (issue_valid[j] && (issue_rd[j*REG_W +: REG_W] == rs_idx)) begin
                hit_fwd = 1'b1;
                fwd_tag = issue_rob_index[j*ROB_W +: ROB_W];
            end
        end
        for (int c = 0; c < COMMIT_PORTS; c++) begin
            if (BYPASS_EN && st_busy && commit_valid[c] &&
                (commit_rob_index[c*ROB_W +: ROB_W] == st_tag)) begin
                hit_byp = 1'b1;
                byp_val = commit_val[c*XLEN +: XLEN];
            end
        end
        if (rs_idx == '0) begin
            src = SRC_ZERO;
        end else if (hit_fwd) begin
            src = SRC_FWD;
        end else if (hit_byp) begin
            src = SRC_BYPASS;
        end else begin
            src = SRC_STORED;
        end
    end

    always_comb begin
        rd_val  = st_val;
        rd_busy = st_busy;
        rd_tag  = st_tag;
        case (src)
            SRC_ZERO: begin
                rd_val  = '0;
                rd_busy = 1'b0;
                rd_tag  = '0;
            end
            SRC_FWD: begin
                rd_busy = 1'b1;
                rd_tag  = fwd_tag;
            end
            SRC_BYPASS: begin
                rd_val  = byp_val;
                rd_busy = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/reg_file_mp.sv
// rtl/reg_file_mp.sv - multi-port register file with busy/tag rename tracking (optional RF_COMMIT_BYPASS_EN)
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int XLEN         = XLEN_DEF,
    parameter int REG_NUM      = REG_NUM_DEF,
    parameter int REG_W        = REG_W_DEF,
    parameter int ROB_W        = ROB_W_DEF,
    parameter int ISSUE_PORTS  = ISSUE_PORTS_DEF,
    parameter int COMMIT_PORTS = COMMIT_PORTS_DEF
) (
    input  logic                            clk_in,
    input  logic                            rst_in,
    input  logic                            rdy_in,
    input  logic                            clr_in,
    input  logic [ISSUE_PORTS-1:0]          issue_valid,
    input  logic [ISSUE_PORTS*REG_W-1:0]    issue_rd,
    input  logic [ISSUE_PORTS*ROB_W-1:0]    issue_rob_index,
    input  logic [2*ISSUE_PORTS*REG_W-1:0]  dc_rs_pos,
    output logic [2*ISSUE_PORTS*XLEN-1:0]   rs_val,
    output logic [2*ISSUE_PORTS-1:0]        rs_busy,
    output logic [2*ISSUE_PORTS*ROB_W-1:0]  rs_tag,
    input  logic [COMMIT_PORTS-1:0]         commit_valid,
    input  logic [COMMIT_PORTS*ROB_W-1:0]   commit_rob_index,
    input  logic [COMMIT_PORTS*REG_W-1:0]   commit_rd,
    input  logic [COMMIT_PORTS*XLEN-1:0]    commit_val
);

    logic [XLEN-1:0]    val_q  [REG_NUM];
    logic [XLEN-1:0]    val_d  [REG_NUM];
    logic [ROB_W-1:0]   tag_q  [REG_NUM];
    logic [ROB_W-1:0]   tag_d  [REG_NUM];
    logic [REG_NUM-1:0] busy_q;
    logic [REG_NUM-1:0] busy_d;

    logic [COMMIT_PORTS-1:0] commit_live;

    // A stalled pipeline must not let a commit look resolved through the bypass
    assign commit_live = commit_valid & {COMMIT_PORTS{rdy_in}};

    always_comb begin
        val_d  = val_q;
        tag_d  = tag_q;
        busy_d = busy_q;
        if (rdy_in) begin
            for (int c = 0; c < COMMIT_PORTS; c++) begin
                if (commit_valid[c] && (commit_rd[c*REG_W +: REG_W] != '0)) begin
                    val_d[commit_rd[c*REG_W +: REG_W]] = commit_val[c*XLEN +: XLEN];
                    if (busy_q[commit_rd[c*REG_W +: REG_W]] &&
                        (tag_q[commit_rd[c*REG_W +: REG_W]] == commit_rob_index[c*ROB_W +: ROB_W])) begin
                        busy_d[commit_rd[c*REG_W +: REG_W]] = 1'b0;
                    end
                end
            end
            // Issues run after commits so a same-register rename keeps its busy/tag
            if (clr_in) begin
                busy_d = '0;
            end else begin
                for (int k = 0; k < ISSUE_PORTS; k++) begin
                    if (issue_valid[k] && (issue_rd[k*REG_W +: REG_W] != '0)) begin
                        busy_d[issue_rd[k*REG_W +: REG_W]] = 1'b1;
                        tag_d[issue_rd[k*REG_W +: REG_W]]  = issue_rob_index[k*ROB_W +: ROB_W];
                    end
                end
            end
        end
        val_d[0]  = '0;
        tag_d[0]  = '0;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int r = 0; r < REG_NUM; r++) begin
                val_q[r] <= '0;
                tag_q[r] <= '0;
            end
            busy_q <= '0;
        end else begin
            val_q  <= val_d;
            tag_q  <= tag_d;
            busy_q <= busy_d;
        end
    end

    for (genvar p = 0; p < 2*ISSUE_PORTS; p++) begin : g_rd
        localparam int SLOT = p / 2;
        localparam logic [ISSUE_PORTS-1:0] OLDER = ISSUE_PORTS'((1 << SLOT) - 1);

        logic [REG_W-1:0] idx;
        logic [XLEN-1:0]  port_val;
        logic             port_busy;
        logic [ROB_W-1:0] port_tag;

        assign idx = dc_rs_pos[p*REG_W +: REG_W];

        rf_read_port #(
            .XLEN         (XLEN),
            .REG_W        (REG_W),
            .ROB_W        (ROB_W),
            .ISSUE_PORTS  (ISSUE_PORTS),
            .COMMIT_PORTS (COMMIT_PORTS)
        ) u_port (
            .rs_idx           (idx),
            .st_val           (val_q[idx]),
            .st_busy          (busy_q[idx]),
            .st_tag           (tag_q[idx]),
            .issue_valid      (issue_valid & OLDER),
            .issue_rd         (issue_rd),
            .issue_rob_index  (issue_rob_index),
            .commit_valid     (commit_live),
            .commit_rob_index (commit_rob_index),
            .commit_val       (commit_val),
            .rd_val           (port_val),
            .rd_busy          (port_busy),
            .rd_tag           (port_tag)
        );

        // Reset must blank reads at once, even while an issue bundle is being forwarded
        assign rs_val[p*XLEN +: XLEN]   = rst_in ? '0 : port_val;
        assign rs_busy[p]               = rst_in ? 1'b0 : port_busy;
        assign rs_tag[p*ROB_W +: ROB_W] = rst_in ? '0 : port_tag;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb/tb_reg_file_mp.sv - scoreboard bench for reg_file_mp against an array-based reference model
module tb_reg_file_mp;

    localparam int XLEN  = 32;
    localparam int RN    = 32;
    localparam int REG_W = 5;
    localparam int ROB_W = 4;
    localparam int IP    = 2;
    localparam int CP    = 2;
    localparam int NP    = 2*IP;

    logic                   clk_in = 1'b0;
    logic                   rst_in;
    logic                   rdy_in;
    logic                   clr_in;
    logic [IP-1:0]          issue_valid;
    logic [IP*REG_W-1:0]    issue_rd;
    logic [IP*ROB_W-1:0]    issue_rob_index;
    logic [NP*REG_W-1:0]    dc_rs_pos;
    logic [NP*XLEN-1:0]     rs_val;
    logic [NP-1:0]          rs_busy;
    logic [NP*ROB_W-1:0]    rs_tag;
    logic [CP-1:0]          commit_valid;
    logic [CP*ROB_W-1:0]    commit_rob_index;
    logic [CP*REG_W-1:0]    commit_rd;
    logic [CP*XLEN-1:0]     commit_val;

    reg_file_mp #(
        .XLEN(XLEN), .REG_NUM(RN), .REG_W(REG_W), .ROB_W(ROB_W),
        .ISSUE_PORTS(IP), .COMMIT_PORTS(CP)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rob_index(issue_rob_index),
        .dc_rs_pos(dc_rs_pos), .rs_val(rs_val), .rs_busy(rs_busy), .rs_tag(rs_tag),
        .commit_valid(commit_valid), .commit_rob_index(commit_rob_index),
        .commit_rd(commit_rd), .commit_val(commit_val)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [31:0]         cyc;
        logic [NP*XLEN-1:0]  val;
        logic [NP-1:0]       busy;
        logic [NP*ROB_W-1:0] tag;
        logic [NP-1:0]       care_val;
    } exp_t;

    exp_t sb_q[$];

    logic [XLEN-1:0]  m_val  [RN];
    logic             m_busy [RN];
    logic [ROB_W-1:0] m_tag  [RN];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic model_clear();
        for (int r = 0; r < RN; r++) begin
            m_val[r]  = '0;
            m_busy[r] = 1'b0;
            m_tag[r]  = '0;
        end
    endtask

    // Expected reads from current model state, then advance the model by this cycle's inputs
    task automatic predict_and_update();
        exp_t             e;
        int               idx, fwd, byp;
        logic [XLEN-1:0]  n_val  [RN];
        logic             n_busy [RN];
        logic [ROB_W-1:0] n_tag  [RN];
        e = '0;
        e.cyc = cyc;
        for (int p = 0; p < NP; p++) begin
            idx = int'(dc_rs_pos[p*REG_W +: REG_W]);
            e.care_val[p] = 1'b1;
            if (rst_in || idx == 0) begin
                e.val[p*XLEN +: XLEN] = '0;
                e.busy[p] = 1'b0;
            end else begin
                fwd = -1;
                for (int j = 0; j < p/2; j++)
                    if (issue_valid[j] && int'(issue_rd[j*REG_W +: REG_W]) == idx) fwd = j;
                byp = -1;
`ifdef RF_COMMIT_BYPASS_EN
                if (rdy_in && m_busy[idx])
                    for (int c = 0; c < CP; c++)
                        if (commit_valid[c] && commit_rob_index[c*ROB_W +: ROB_W] == m_tag[idx]) byp = c;
`endif
                if (fwd >= 0) begin
                    e.busy[p] = 1'b1;
                    e.tag[p*ROB_W +: ROB_W] = issue_rob_index[fwd*ROB_W +: ROB_W];
                    e.care_val[p] = 1'b0;
                end else if (byp >= 0) begin
                    e.val[p*XLEN +: XLEN] = commit_val[byp*XLEN +: XLEN];
                    e.busy[p] = 1'b0;
                end else begin
                    e.val[p*XLEN +: XLEN] = m_val[idx];
                    e.busy[p] = m_busy[idx];
                    e.tag[p*ROB_W +: ROB_W] = m_tag[idx];
                end
            end
        end
        sb_q.push_back(e);

        if (rst_in) begin
            model_clear();
        end else if (rdy_in) begin
            n_val = m_val; n_busy = m_busy; n_tag = m_tag;
            for (int c = 0; c < CP; c++) begin
                idx = int'(commit_rd[c*REG_W +: REG_W]);
                if (commit_valid[c] && idx != 0) begin
                    n_val[idx] = commit_val[c*XLEN +: XLEN];
                    if (m_busy[idx] && m_tag[idx] == commit_rob_index[c*ROB_W +: ROB_W]) n_busy[idx] = 1'b0;
                end
            end
            if (clr_in) begin
                for (int r = 0; r < RN; r++) n_busy[r] = 1'b0;
            end else begin
                for (int k = 0; k < IP; k++) begin
                    idx = int'(issue_rd[k*REG_W +: REG_W]);
                    if (issue_valid[k] && idx != 0) begin
                        n_busy[idx] = 1'b1;
                        n_tag[idx]  = issue_rob_index[k*ROB_W +: ROB_W];
                    end
                end
            end
            m_val = n_val; m_busy = n_busy; m_tag = n_tag;
        end
    endtask

    always @(negedge clk_in) begin
        exp_t e;
        logic ok;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            for (int p = 0; p < NP; p++) begin
                n_checks++;
                ok = (rs_busy[p] == e.busy[p]);
                if (e.care_val[p] && rs_val[p*XLEN +: XLEN] !== e.val[p*XLEN +: XLEN]) ok = 1'b0;
                if (e.busy[p] && rs_tag[p*ROB_W +: ROB_W] !== e.tag[p*ROB_W +: ROB_W]) ok = 1'b0;
                if (!ok) begin
                    n_fail++;
                    $display("FAIL read_port%0d cyc%0d: got val=%h busy=%b tag=%0d, expected val=%h busy=%b tag=%0d",
                             p, e.cyc, rs_val[p*XLEN +: XLEN], rs_busy[p], rs_tag[p*ROB_W +: ROB_W],
                             e.val[p*XLEN +: XLEN], e.busy[p], e.tag[p*ROB_W +: ROB_W]);
                end
            end
        end
    end

    task automatic idle();
        rst_in = 1'b0; rdy_in = 1'b1; clr_in = 1'b0;
        issue_valid = '0; issue_rd = '0; issue_rob_index = '0;
        commit_valid = '0; commit_rd = '0; commit_rob_index = '0; commit_val = '0;
        dc_rs_pos = '0;
    endtask

    task automatic set_issue(input int s, input int rd, input int tag);
        issue_valid[s] = 1'b1;
        issue_rd[s*REG_W +: REG_W] = REG_W'(rd);
        issue_rob_index[s*ROB_W +: ROB_W] = ROB_W'(tag);
    endtask

    task automatic set_commit(input int c, input int rd, input int tag, input logic [XLEN-1:0] v);
        commit_valid[c] = 1'b1;
        commit_rd[c*REG_W +: REG_W] = REG_W'(rd);
        commit_rob_index[c*ROB_W +: ROB_W] = ROB_W'(tag);
        commit_val[c*XLEN +: XLEN] = v;
    endtask

    task automatic set_read(input int p, input int idx);
        dc_rs_pos[p*REG_W +: REG_W] = REG_W'(idx);
    endtask

    task automatic step();
        predict_and_update();
        @(posedge clk_in);
        #1;
        cyc++;
    endtask

    initial begin
        idle();
        rst_in = 1'b1;
        model_clear();
        @(posedge clk_in);
        #1;
        set_issue(0, 5, 3);
        set_read(2, 5);
        step();

        idle(); set_read(0, 5); set_read(1, 0); step();

        idle(); set_issue(0, 3, 0); set_read(0, 3); set_read(2, 3); step();
        idle(); set_read(0, 3); step();
        idle(); set_commit(0, 3, 0, 32'hDEADBEEF); set_read(1, 3); step();
        idle(); set_read(0, 3); step();

        idle(); set_issue(0, 3, 6); step();
        idle(); set_issue(0, 3, 9); step();
        idle(); set_commit(0, 3, 6, 32'd1); step();
        idle(); set_read(0, 3); step();

        idle(); set_issue(0, 4, 2); step();
        idle(); set_commit(1, 4, 2, 32'd7); set_issue(0, 4, 5); step();
        idle(); set_read(3, 4); step();

        idle(); set_issue(0, 8, 3); set_read(2, 8); step();
        idle(); set_issue(0, 0, 7); set_read(2, 0); set_read(3, 8); step();

        for (int i = 0; i < 16; i++) begin
            idle();
            set_issue(0, 2*i+1, i);
            if (2*i+2 < RN) set_issue(1, 2*i+2, i+1);
            step();
        end
        idle(); clr_in = 1'b1; set_commit(0, 2, 4, 32'h55); set_issue(0, 9, 12);
        set_read(0, 2); set_read(1, 9); step();
        idle(); set_read(0, 2); set_read(1, 9); set_read(2, 31); set_read(3, 1); step();

        idle(); set_issue(0, 6, 1); step();
        for (int i = 0; i < 3; i++) begin
            idle(); rdy_in = 1'b0; clr_in = (i == 1);
            set_issue(0, 7, 2); set_commit(0, 6, 1, 32'h1234); set_read(0, 6); set_read(1, 7);
            step();
        end
        idle(); set_read(0, 6); set_read(1, 7); step();

        idle(); set_issue(0, 7, 11); step();
        idle(); set_commit(0, 7, 11, 32'hCAFE0007); set_commit(1, 12, 11, 32'h0000BEEF);
        set_read(0, 7); step();
        idle(); set_read(0, 7); step();

        for (int n = 0; n < 1500; n++) begin
            int r;
            idle();
            rdy_in = ($urandom_range(7) != 0);
            clr_in = ($urandom_range(15) == 0);
            rst_in = ($urandom_range(149) == 0);
            for (int k = 0; k < IP; k++)
                if ($urandom_range(1) == 1) set_issue(k, $urandom_range(7), $urandom_range(15));
            for (int c = 0; c < CP; c++) begin
                if ($urandom_range(1) == 1) begin
                    r = $urandom_range(7);
                    set_commit(c, r, ($urandom_range(1) == 1) ? int'(m_tag[r]) : $urandom_range(15), $urandom);
                end
            end
            for (int p = 0; p < NP; p++)
                set_read(p, ($urandom_range(9) == 0) ? $urandom_range(31) : $urandom_range(7));
            step();
        end

        idle();
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk_in);
        if (sb_q.size() > 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
